// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers addressed by
// word index addr[31:2]. Independent read FSM and write path; out-of-range
// accesses answer SLVERR. Optional byte-strobe support is enabled by
// defining AXI4LITE_REGFILE_WSTRB_EN; without it every in-range write
// replaces the whole word.
module axi4lite_slave_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready
);

    localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Merge new data into an old word, byte lane k taken from new when strb[k].
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Register storage and state
    logic [31:0]      regs_r [NUM_REGS];
    rd_state_t        rd_state_r;
    rd_state_t        rd_state_s;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;
    logic             aw_held_r;
    logic             w_held_r;
    logic [31:0]      awaddr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wstrb_r;
    logic             bvalid_r;
    logic [1:0]       bresp_r;

    // Combinational helpers
    logic             arready_s;
    logic             rvalid_s;
    logic             ar_hs_s;
    logic             rd_in_range_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [31:0]      rd_word_s;
    logic             awready_s;
    logic             wready_s;
    logic             aw_hs_s;
    logic             w_hs_s;
    logic             commit_s;
    logic [31:0]      wr_addr_s;
    logic [31:0]      wr_data_s;
    logic [3:0]       wr_strb_s;
    logic             wr_in_range_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [31:0]      wr_word_s;
    logic             unused_s;

    assign rd_in_range_s = (s_axi_araddr[31:2] < 30'(NUM_REGS));
    assign rd_idx_s      = s_axi_araddr[IDX_W+1:2];

    assign awready_s     = !aw_held_r && !bvalid_r;
    assign wready_s      = !w_held_r && !bvalid_r;
    assign aw_hs_s       = s_axi_awvalid && awready_s;
    assign w_hs_s        = s_axi_wvalid && wready_s;
    assign commit_s      = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    assign wr_in_range_s = (wr_addr_s[31:2] < 30'(NUM_REGS));
    assign wr_idx_s      = wr_addr_s[IDX_W+1:2];

    // Sub-word address bits and (without strobes) the strobe path are unused.
    assign unused_s = ^{s_axi_araddr[1:0], wr_addr_s[1:0], wr_strb_s};

    // Read FSM next-state and handshake decode.
    always_comb begin
        rd_state_s = rd_state_r;
        arready_s  = 1'b0;
        rvalid_s   = 1'b0;
        ar_hs_s    = 1'b0;
        case (rd_state_r)
            R_IDLE: begin
                arready_s = 1'b1;
                if (s_axi_arvalid) begin
                    ar_hs_s    = 1'b1;
                    rd_state_s = R_DATA;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                rvalid_s = 1'b1;
                if (s_axi_rready) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_DATA;
                end
            end
            default: begin
                rd_state_s = R_IDLE;
            end
        endcase
    end

    // Read word selection; out-of-range reads return zero.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (rd_in_range_s) begin
            rd_word_s = regs_r[rd_idx_s];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Read FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Capture read data/response on the AR handshake; held through R_DATA.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rdata_r <= 32'h0000_0000;
            rresp_r <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rdata_r <= rd_word_s;
            rresp_r <= rd_in_range_s ? RESP_OKAY : RESP_SLV;
        end
    end

    // Pick held or live AW/W values for the commit.
    always_comb begin
        wr_addr_s = s_axi_awaddr;
        wr_data_s = s_axi_wdata;
        wr_strb_s = s_axi_wstrb;
        if (aw_held_r) begin
            wr_addr_s = awaddr_r;
        end else begin
            wr_addr_s = s_axi_awaddr;
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = s_axi_wdata;
            wr_strb_s = s_axi_wstrb;
        end
    end

    // Word written on commit: strobe-merged or full replacement.
    always_comb begin
        wr_word_s = wr_data_s;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
        wr_word_s = merge_bytes(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
`else
        wr_word_s = wr_data_s;
`endif
    end

    // AW/W hold flags and B channel; commit clears both flags and raises bvalid.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else if (commit_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_in_range_s ? RESP_OKAY : RESP_SLV;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awaddr_r  <= s_axi_awaddr;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= s_axi_wdata;
                wstrb_r  <= s_axi_wstrb;
            end
            if (bvalid_r && s_axi_bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Register array: reset to RESET_VALUE, in-range commits update one word.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
        end else if (commit_s && wr_in_range_s) begin
            regs_r[wr_idx_s] <= wr_word_s;
        end
    end

    assign s_axi_arready = arready_s;
    assign s_axi_rvalid  = rvalid_s;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_awready = awready_s;
    assign s_axi_wready  = wready_s;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Self-checking bench for axi4lite_slave_regfile (NUM_REGS=16). Directed
// steps followed by randomized reads/writes against an array model.
module tb_axi4lite_slave_regfile;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [16];

    axi4lite_slave_regfile #(.NUM_REGS(16), .RESET_VALUE(RV)) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    // Reference model: apply a write using plain per-byte rules.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] exp_resp);
        int idx;
        idx = int'(addr >> 2);
        if (idx < 16) begin
`ifdef AXI4LITE_REGFILE_WSTRB_EN
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
            end
`else
            logic unused_strb;
            unused_strb = ^strb;
            model[idx] = data;
`endif
            exp_resp = 2'b00;
        end else begin
            exp_resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr >> 2);
        if (idx < 16) begin
            data = model[idx];
            resp = 2'b00;
        end else begin
            data = 32'h0000_0000;
            resp = 2'b10;
        end
    endtask

    // AXI read; hold = cycles rready stays low once rvalid is up.
    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        cyc = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        while (!s_axi_arready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ar_wait", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        chk("r_latency", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("r_stable_data", s_axi_rdata, data);
            chk("r_stable_resp", 32'(s_axi_rresp), 32'(resp));
            chk("r_arready_low", 32'(s_axi_arready), 32'd0);
            chk("r_valid_held", 32'(s_axi_rvalid), 32'd1);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        chk("r_done", 32'(s_axi_rvalid), 32'd0);
    endtask

    // AXI write; lead>0: W first, AW lead cycles later; lead<0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input bit auto_b,
                            output logic [1:0] resp);
        int cyc;
        int aw_start;
        int w_start;
        logic aw_done;
        logic w_done;
        logic aw_f;
        logic w_f;
        cyc      = 0;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        aw_start = (lead < 0) ? 0 : lead;
        w_start  = (lead < 0) ? -lead : 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_bready  = 1'b0;
        s_axi_awvalid = (aw_start == 0);
        s_axi_wvalid  = (w_start == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            cyc++;
            if (aw_f) begin
                s_axi_awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_f) begin
                s_axi_wvalid = 1'b0;
                w_done = 1'b1;
            end
            if (w_done && !aw_done) chk("w_ready_low_held", 32'(s_axi_wready), 32'd0);
            if (aw_done && !w_done) chk("aw_ready_low_held", 32'(s_axi_awready), 32'd0);
            if (!aw_done && cyc >= aw_start) s_axi_awvalid = 1'b1;
            if (!w_done && cyc >= w_start) s_axi_wvalid = 1'b1;
        end
        chk("wr_handshakes", 32'(aw_done && w_done), 32'd1);
        chk("b_latency", 32'(s_axi_bvalid), 32'd1);
        resp = s_axi_bresp;
        if (auto_b) begin
            s_axi_bready = 1'b1;
            tick();
            s_axi_bready = 1'b0;
            chk("b_done", 32'(s_axi_bvalid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;

        s_axi_aresetn = 1'b0;
        s_axi_araddr  = 32'h0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_awaddr  = 32'h0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = RV;

        // Reset state, before any clock edge.
        #2;
        chk("rst_arready", 32'(s_axi_arready), 32'd1);
        chk("rst_awready", 32'(s_axi_awready), 32'd1);
        chk("rst_wready",  32'(s_axi_wready),  32'd1);
        chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        chk("rst_rdata",   s_axi_rdata,        32'd0);
        chk("rst_rresp",   32'(s_axi_rresp),   32'd0);
        chk("rst_bresp",   32'(s_axi_bresp),   32'd0);
        repeat (2) @(posedge s_axi_aclk);
        #1;
        s_axi_aresetn = 1'b1;

        // Read of a reset register.
        do_read(32'h08, 0, d, r);
        chk("rd08_data", d, RV);
        chk("rd08_resp", 32'(r), 32'd0);

        // AW and W together.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 1'b1, r);
        model_write(32'h04, 32'hDEADBEEF, 4'hF, er);
        chk("wr04_bresp", 32'(r), 32'(er));
        do_read(32'h04, 0, d, r);
        chk("rd04_data", d, 32'hDEADBEEF);

        // W three cycles ahead of AW; exactly one B response.
        do_write(32'h0C, 32'h12345678, 4'hF, 3, 1'b1, r);
        model_write(32'h0C, 32'h12345678, 4'hF, er);
        chk("wr0c_bresp", 32'(r), 32'(er));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr0c_single_b", 32'(s_axi_bvalid), 32'd0);
        end
        do_read(32'h0C, 0, d, r);
        chk("rd0c_data", d, 32'h12345678);

        // AW ahead of W.
        do_write(32'h18, 32'h0BADCAFE, 4'hF, -2, 1'b1, r);
        model_write(32'h18, 32'h0BADCAFE, 4'hF, er);
        chk("wr18_bresp", 32'(r), 32'(er));

        // Out-of-range read (rready held low 5 cycles) and write.
        do_read(32'h40, 5, d, r);
        chk("rd40_data", d, 32'd0);
        chk("rd40_resp", 32'(r), 32'd2);
        do_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, 1'b1, r);
        model_write(32'h40, 32'hA5A5A5A5, 4'hF, er);
        chk("wr40_bresp", 32'(r), 32'd2);
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0, d, r);
            chk("oor_regs_unchanged", d, model[i]);
        end

        // Byte-strobe behaviour.
        do_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 1'b1, r);
        model_write(32'h00, 32'hFFFFFFFF, 4'hF, er);
        do_write(32'h00, 32'h00AB00CD, 4'b0101, 0, 1'b1, r);
        model_write(32'h00, 32'h00AB00CD, 4'b0101, er);
        chk("strb_bresp", 32'(r), 32'd0);
        do_read(32'h00, 0, d, r);
`ifdef AXI4LITE_REGFILE_WSTRB_EN
        chk("strb_merge", d, 32'hFFABFFCD);
`else
        chk("strb_ignored", d, 32'h00AB00CD);
`endif
        do_write(32'h10, 32'h11111111, 4'h0, 0, 1'b1, r);
        model_write(32'h10, 32'h11111111, 4'h0, er);
        chk("strb0_bresp", 32'(r), 32'd0);
        do_read(32'h10, 0, d, r);
        chk("strb0_data", d, model[4]);

        // Read and write of the same register on the same edge.
        ed = model[3];
        s_axi_araddr  = 32'h0C;
        s_axi_arvalid = 1'b1;
        s_axi_awaddr  = 32'h0C;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'hCAFEF00D;
        s_axi_wstrb   = 4'hF;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("rw_same_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rw_same_old", s_axi_rdata, ed);
        chk("rw_same_bvalid", 32'(s_axi_bvalid), 32'd1);
        model_write(32'h0C, 32'hCAFEF00D, 4'hF, er);
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        do_read(32'h0C, 0, d, r);
        chk("rw_same_new", d, model[3]);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
                do_write(a, wd, ws, $urandom_range(0, 4) - 2, 1'b1, r);
                model_write(a, wd, ws, er);
                chk("rand_bresp", 32'(r), 32'(er));
            end else begin
                do_read(a, $urandom_range(0, 2), d, r);
                model_read(a, ed, er);
                chk("rand_rdata", d, ed);
                chk("rand_rresp", 32'(r), 32'(er));
            end
        end

        // Reset while a B response and an R response are pending.
        do_write(32'h14, 32'h55AA55AA, 4'hF, 0, 1'b0, r);
        s_axi_araddr  = 32'h04;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("pre_rst_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("pre_rst_bvalid", 32'(s_axi_bvalid), 32'd1);
        #2;
        s_axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        chk("mid_rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("mid_rst_arready", 32'(s_axi_arready), 32'd1);
        chk("mid_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("mid_rst_wready",  32'(s_axi_wready),  32'd1);
        chk("mid_rst_rdata",   s_axi_rdata,        32'd0);
        for (int i = 0; i < 16; i++) model[i] = RV;
        repeat (2) @(posedge s_axi_aclk);
        #1;
        s_axi_aresetn = 1'b1;
        tick();
        chk("post_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0, d, r);
            chk("post_rst_regs", d, model[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
